freq_gate_ctrl: RTL and testbench
=================================

Name: freq_gate_ctrl

Overview:
- Equal-precision (reciprocal) frequency-measurement controller, fully in the sysClk domain.
- Synchronises the asynchronous input `signal`, opens a measurement gate on a signal rising edge, and keeps the gate open for at least gateCycles reference cycles.
- Closes the gate on the next signal edge, so the window always spans an integer number of signal periods.
- Publishes refCount/sigCount through a valid/ready result port. Feeds the frequency/period computation logic downstream; software or a host FSM drives start/abort.

Parameters:
- CNT_W, 32, width of reference and signal counters and result outputs.
- GATE_W, 32, width of gateCycles and timeoutCycles.
- SYNC_STAGES, 2, synchroniser depth for `signal` (minimum 2).

Ports:
- sysClk  in  1  system/reference clock.
- sysRst  in  1  reset, asynchronous, active-high.
- signal  in  1  measured signal, asynchronous to sysClk.
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE with no result.
- contMode  in  1  1 = re-arm automatically after each accepted result.
- gateCycles  in  GATE_W  minimum gate length in sysClk cycles; 0 is treated as 1.
- timeoutCycles  in  GATE_W  maximum wait for a signal edge in ARM/CLOSE.
- busy  out  1  high in any state other than IDLE.
- resValid  out  1  result valid.
- resReady  in  1  result accepted when resValid and resReady are both high.
- refCount  out  CNT_W  sysClk cycles in the gate.
- sigCount  out  CNT_W  signal periods in the gate.
- timeout  out  1  result ended by timeout.
- overflow  out  1  refCount or sigCount saturated.

Behaviour:
- Reset: state=IDLE. busy, resValid, timeout, overflow, refCount, sigCount, and the internal counters all reset to 0.
- Edge detect: SYNC_STAGES flops, then edge = sync & ~sync_d. An edge is visible SYNC_STAGES+1 cycles after the input transition. Only rising edges count.
- States: IDLE, ARM, GATE, CLOSE, DONE.
- IDLE:
  - start & ~abort → ARM.
  - Clear the timeout counter.
- ARM:
  - On an edge: refCnt←0, sigCnt←0, ovf←0, latch gateCycles (0→1), clear the timeout counter → GATE.
  - Otherwise the timeout counter increments. When it reaches timeoutCycles → DONE with timeout=1, refCount=0, sigCount=0.
- GATE: every cycle refCnt+1 (saturating); sigCnt+1 on each edge.
  - If the new refCnt ≥ latched gate and an edge occurs in this cycle → DONE. This is the coincident-edge case.
  - Else if the new refCnt ≥ latched gate → CLOSE, clear the timeout counter.
- CLOSE:
  - refCnt keeps incrementing and the timeout counter increments.
  - The first edge increments sigCnt → DONE.
  - Timeout → DONE with timeout=1 and the current counts.
- DONE entry: refCount/sigCount/overflow/timeout are registered from the final counts (including the closing cycle), and resValid=1.
  - Outputs stay stable while resValid=1 and resReady=0.
  - On handshake, resValid drops the next cycle, then → ARM if contMode, else → IDLE.
  - Result outputs hold their last value until the next DONE.
- Count invariant: for signal period P cycles and N periods, refCount=N·P and sigCount=N.
- Saturation: counters stick at 2^CNT_W−1, set the internal ovf flag, and the measurement still completes normally.
- abort: in any state, next state = IDLE.
  - Aborting in DONE discards the pending result: resValid←0, result outputs unchanged.
  - abort has priority over start, over edges, and over the handshake in the same cycle.
- start outside IDLE is ignored. gateCycles/timeoutCycles changes mid-measurement affect only the next gate open (gate value) or take effect immediately (timeout).
- Reset mid-operation returns everything to reset values; no partial result is emitted.

Decomposition:
- freq_meter_pkg holds:
  - the state enum (IDLE/ARM/GATE/CLOSE/DONE);
  - default CNT_W/GATE_W constants;
  - a saturating-increment function.
- One sub-module, sig_edge_sync: the SYNC_STAGES synchroniser plus rising-edge pulse, reused by other measurement blocks.

Test Plan:
- Signal period 10 cycles, gateCycles=95, start → resValid once with refCount=100, sigCount=10, timeout=0, overflow=0.
- Period 10, gateCycles=100 (edge coincides with gate expiry) → skips CLOSE, refCount=100, sigCount=10.
- Signal held low, timeoutCycles=50, start → resValid about 50 cycles after entering ARM, timeout=1, counts 0. Separately, the signal stops after gate open → timeout=1 with partial counts.
- contMode=1, resReady held low 20 cycles → outputs stable and no new gate opens. After the handshake → ARM, then a second identical result.
- CNT_W=8, period 4, gateCycles=300 → refCount=255 (saturated), overflow=1, valid result still produced.
- abort asserted mid-GATE, and abort+start in the same IDLE cycle → IDLE with busy=0 and no resValid. sysRst mid-CLOSE → all outputs 0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the reciprocal frequency-measurement blocks.
package freq_meter_pkg;

   localparam int unsigned CntWDefault  = 32;
   localparam int unsigned GateWDefault = 32;
   localparam int unsigned SatMaxW      = 64;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StGate,
      StClose,
      StDone
   } state_e;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [SatMaxW-1:0] sat_inc(input logic [SatMaxW-1:0] val,
                                                  input int unsigned         width);
      logic [SatMaxW-1:0] max_val;
      max_val = (width >= SatMaxW) ? '1 : ((SatMaxW'(1) << width) - SatMaxW'(1));
      return (val >= max_val) ? max_val : val + SatMaxW'(1);
   endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Multi-stage synchroniser for an asynchronous input plus a rising-edge pulse.
module sig_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic sysClk,
   input  logic sysRst,
   input  logic signal_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   always_ff @(posedge sysClk or posedge sysRst) begin
      if (sysRst) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
         last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Equal-precision frequency-measurement controller: gate opens and closes on signal
// rising edges, counting reference cycles and signal periods inside the window.
module freq_gate_ctrl
   import freq_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = CntWDefault,
   parameter int unsigned GATE_W      = GateWDefault,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              sysClk,
   input  logic              sysRst,
   input  logic              signal_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              contMode_i,
   input  logic [GATE_W-1:0] gateCycles_i,
   input  logic [GATE_W-1:0] timeoutCycles_i,
   output logic              busy_o,
   output logic              resValid_o,
   input  logic              resReady_i,
   output logic [CNT_W-1:0]  refCount_o,
   output logic [CNT_W-1:0]  sigCount_o,
   output logic              timeout_o,
   output logic              overflow_o
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  ref_q, ref_d, sig_q, sig_d;
   logic [CNT_W-1:0]  res_ref_q, res_ref_d, res_sig_q, res_sig_d;
   logic [GATE_W-1:0] gate_q, gate_d, gcnt_q, gcnt_d, tmo_q, tmo_d;
   logic              ovf_q, ovf_d;
   logic              res_valid_q, res_valid_d, res_tmo_q, res_tmo_d, res_ovf_q, res_ovf_d;

   logic              sig_edge;
   logic [CNT_W-1:0]  ref_inc, sig_inc, sig_new;
   logic [GATE_W-1:0] gcnt_inc, tmo_inc;
   logic              ovf_new, gate_done, tmo_hit;
   logic              fin, fin_tmo, fin_ovf;
   logic [CNT_W-1:0]  fin_ref, fin_sig;

   sig_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .sysClk  (sysClk),
      .sysRst  (sysRst),
      .signal_i(signal_i),
      .edge_o  (sig_edge)
   );

   assign ref_inc  = CNT_W'(sat_inc(SatMaxW'(ref_q), CNT_W));
   assign sig_inc  = CNT_W'(sat_inc(SatMaxW'(sig_q), CNT_W));
   assign sig_new  = sig_edge ? sig_inc : sig_q;
   assign ovf_new  = ovf_q | (ref_q == '1) | (sig_edge & (sig_q == '1));
   // Gate length is tracked separately so a saturated refCnt cannot stall the close.
   assign gcnt_inc  = GATE_W'(sat_inc(SatMaxW'(gcnt_q), GATE_W));
   assign tmo_inc   = GATE_W'(sat_inc(SatMaxW'(tmo_q), GATE_W));
   assign gate_done = (gcnt_inc >= gate_q);
   assign tmo_hit   = (tmo_inc >= timeoutCycles_i);

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      sig_d       = sig_q;
      ovf_d       = ovf_q;
      gate_d      = gate_q;
      gcnt_d      = gcnt_q;
      tmo_d       = tmo_q;
      res_valid_d = res_valid_q;
      res_ref_d   = res_ref_q;
      res_sig_d   = res_sig_q;
      res_tmo_d   = res_tmo_q;
      res_ovf_d   = res_ovf_q;
      fin         = 1'b0;
      fin_ref     = ref_inc;
      fin_sig     = sig_new;
      fin_ovf     = ovf_new;
      fin_tmo     = 1'b0;
      if (abort_i) begin
         state_d     = StIdle;
         res_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               tmo_d = '0;
               if (start_i) state_d = StArm;
            end
            StArm: begin
               if (sig_edge) begin
                  ref_d   = '0;
                  sig_d   = '0;
                  ovf_d   = 1'b0;
                  gcnt_d  = '0;
                  tmo_d   = '0;
                  gate_d  = (gateCycles_i == '0) ? GATE_W'(1) : gateCycles_i;
                  state_d = StGate;
               end else begin
                  tmo_d = tmo_inc;
                  if (tmo_hit) begin
                     fin     = 1'b1;
                     fin_tmo = 1'b1;
                     fin_ref = '0;
                     fin_sig = '0;
                     fin_ovf = 1'b0;
                  end
               end
            end
            StGate: begin
               ref_d  = ref_inc;
               sig_d  = sig_new;
               ovf_d  = ovf_new;
               gcnt_d = gcnt_inc;
               if (gate_done && sig_edge) begin
                  fin = 1'b1;
               end else if (gate_done) begin
                  tmo_d   = '0;
                  state_d = StClose;
               end
            end
            StClose: begin
               ref_d = ref_inc;
               sig_d = sig_new;
               ovf_d = ovf_new;
               tmo_d = tmo_inc;
               if (sig_edge) begin
                  fin = 1'b1;
               end else if (tmo_hit) begin
                  fin     = 1'b1;
                  fin_tmo = 1'b1;
               end
            end
            StDone: begin
               if (res_valid_q && resReady_i) begin
                  res_valid_d = 1'b0;
                  tmo_d       = '0;
                  state_d     = contMode_i ? StArm : StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      if (fin) begin
         state_d     = StDone;
         res_valid_d = 1'b1;
         res_ref_d   = fin_ref;
         res_sig_d   = fin_sig;
         res_tmo_d   = fin_tmo;
         res_ovf_d   = fin_ovf;
      end
   end

   always_ff @(posedge sysClk or posedge sysRst) begin
      if (sysRst) begin
         state_q     <= StIdle;
         ref_q       <= '0;
         sig_q       <= '0;
         ovf_q       <= 1'b0;
         gate_q      <= '0;
         gcnt_q      <= '0;
         tmo_q       <= '0;
         res_valid_q <= 1'b0;
         res_ref_q   <= '0;
         res_sig_q   <= '0;
         res_tmo_q   <= 1'b0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         sig_q       <= sig_d;
         ovf_q       <= ovf_d;
         gate_q      <= gate_d;
         gcnt_q      <= gcnt_d;
         tmo_q       <= tmo_d;
         res_valid_q <= res_valid_d;
         res_ref_q   <= res_ref_d;
         res_sig_q   <= res_sig_d;
         res_tmo_q   <= res_tmo_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

   assign busy_o     = (state_q != StIdle);
   assign resValid_o = res_valid_q;
   assign refCount_o = res_ref_q;
   assign sigCount_o = res_sig_q;
   assign timeout_o  = res_tmo_q;
   assign overflow_o = res_ovf_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: vector table, random runs against a
// period-arithmetic model, and hand-written corner sequences.
module tb_freq_gate_ctrl;

   logic        sysClk = 1'b0;
   logic        sysRst = 1'b1;
   logic        signal = 1'b0;
   logic        start = 1'b0, abort = 1'b0, contMode = 1'b0, resReady = 1'b0;
   logic [31:0] gateCycles = 32'd95, timeoutCycles = 32'd1000;

   logic        busy, resValid, timeout, overflow;
   logic [31:0] refCount, sigCount;
   logic        busy8, resValid8, timeout8, overflow8;
   logic [7:0]  refCount8, sigCount8;

   int n_cmp  = 0;
   int n_fail = 0;
   int period = 10;
   bit sig_en = 1'b0;

   freq_gate_ctrl dut (
      .sysClk(sysClk), .sysRst(sysRst), .signal_i(signal), .start_i(start), .abort_i(abort),
      .contMode_i(contMode), .gateCycles_i(gateCycles), .timeoutCycles_i(timeoutCycles),
      .busy_o(busy), .resValid_o(resValid), .resReady_i(resReady), .refCount_o(refCount),
      .sigCount_o(sigCount), .timeout_o(timeout), .overflow_o(overflow)
   );

   freq_gate_ctrl #(.CNT_W(8)) dut8 (
      .sysClk(sysClk), .sysRst(sysRst), .signal_i(signal), .start_i(start), .abort_i(abort),
      .contMode_i(contMode), .gateCycles_i(gateCycles), .timeoutCycles_i(timeoutCycles),
      .busy_o(busy8), .resValid_o(resValid8), .resReady_i(resReady), .refCount_o(refCount8),
      .sigCount_o(sigCount8), .timeout_o(timeout8), .overflow_o(overflow8)
   );

   always #5 sysClk = ~sysClk;

   // Periodic test signal: low for period/2 cycles, then high, restarting when disabled.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge sysClk);
         #2;
         if (!sig_en) begin
            ph     = 0;
            signal = 1'b0;
         end else begin
            ph     = (ph + 1 >= period) ? 0 : ph + 1;
            signal = (ph >= period / 2);
         end
      end
   end

   typedef struct {
      int     p;
      int     g;
      int     t;
      longint r;
      longint s;
      bit     to;
      bit     ov;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Window spans the whole signal periods needed to cover the gate length.
   function automatic void model(input int p, input int g, input int unsigned w,
                                 output longint r, output longint s, output bit ov);
      longint g1, n, full, mx;
      g1   = (g == 0) ? 1 : g;
      n    = (g1 + p - 1) / p;
      full = n * p;
      mx   = (longint'(1) << w) - 1;
      ov   = (full > mx);
      r    = ov ? mx : full;
      s    = n;
   endfunction

   task automatic wait_valid(input string name, input int bound, output int n);
      n = 0;
      while (!resValid && n < bound) begin
         tick();
         n++;
      end
      check(name, resValid, 1);
   endtask

   task automatic prep(input int p, input int g, input int t);
      gateCycles    = g;
      timeoutCycles = t;
      sig_en        = 1'b0;
      period        = p;
      repeat (3) tick();
      sig_en = 1'b1;
   endtask

   task automatic run_meas(input int p, input int g, input int t);
      int n;
      prep(p, g, t);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("result_valid", 3000, n);
   endtask

   task automatic handshake();
      resReady = 1'b1;
      tick();
      resReady = 1'b0;
   endtask

   initial begin
      int     n;
      bit     seen;
      longint er, es;
      bit     eo;

      vecs[0] = '{10, 95, 1000, 100, 10, 1'b0, 1'b0};
      vecs[1] = '{10, 100, 1000, 100, 10, 1'b0, 1'b0};
      vecs[2] = '{7, 0, 1000, 7, 1, 1'b0, 1'b0};
      vecs[3] = '{5, 23, 1000, 25, 5, 1'b0, 1'b0};
      vecs[4] = '{12, 12, 1000, 12, 1, 1'b0, 1'b0};

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_valid", resValid, 0);
      check("rst_ref", refCount, 0);
      check("rst_sig", sigCount, 0);
      check("rst_flags", {timeout, overflow}, 0);
      sysRst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         run_meas(vecs[i].p, vecs[i].g, vecs[i].t);
         check($sformatf("vec%0d_ref", i), refCount, vecs[i].r);
         check($sformatf("vec%0d_sig", i), sigCount, vecs[i].s);
         check($sformatf("vec%0d_tmo", i), timeout, vecs[i].to);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ov);
         handshake();
         check($sformatf("vec%0d_idle", i), {busy, resValid}, 0);
      end

      for (int i = 0; i < 6; i++) begin
         int p, g;
         p = $urandom_range(3, 16);
         g = $urandom_range(0, 120);
         model(p, g, 32, er, es, eo);
         run_meas(p, g, 1000);
         check($sformatf("rnd%0d_ref(p=%0d,g=%0d)", i, p, g), refCount, er);
         check($sformatf("rnd%0d_sig", i), sigCount, es);
         check($sformatf("rnd%0d_flags", i), {timeout, overflow}, {1'b0, eo});
         handshake();
      end

      // Signal never toggles: ARM times out with empty counts.
      prep(10, 95, 50);
      sig_en = 1'b0;
      start  = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("arm_tmo_valid", 200, n);
      check("arm_tmo_latency", (n >= 45 && n <= 55), 1);
      check("arm_tmo_flag", timeout, 1);
      check("arm_tmo_counts", {refCount, sigCount}, 0);
      handshake();

      // Signal stops after the gate opens: CLOSE times out with partial counts.
      prep(10, 30, 40);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (25) tick();
      sig_en = 1'b0;
      wait_valid("close_tmo_valid", 300, n);
      check("close_tmo_flag", timeout, 1);
      check("close_tmo_ref", refCount, 70);
      check("close_tmo_sig", (sigCount >= 1 && sigCount <= 2), 1);
      handshake();

      // Continuous mode with back-pressure.
      contMode = 1'b1;
      run_meas(10, 95, 1000);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_valid", resValid, 1);
         check("hold_ref", refCount, 100);
         check("hold_sig", sigCount, 10);
      end
      handshake();
      check("cont_drop_valid", resValid, 0);
      check("cont_rearm_busy", busy, 1);
      wait_valid("cont_second_valid", 500, n);
      check("cont_second_ref", refCount, 100);
      check("cont_second_sig", sigCount, 10);
      contMode = 1'b0;
      handshake();
      check("cont_idle", busy, 0);

      // Narrow counter saturates but still delivers a result.
      run_meas(4, 300, 1000);
      check("sat_valid8", resValid8, 1);
      check("sat_ref8", refCount8, 255);
      check("sat_sig8", sigCount8, 75);
      check("sat_ovf8", overflow8, 1);
      check("sat_tmo8", timeout8, 0);
      check("sat_ref32", refCount, 300);
      check("sat_ovf32", overflow, 0);
      handshake();

      // Abort mid-GATE.
      prep(10, 95, 1000);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (resValid || busy) seen = 1'b1;
      end
      check("abort_no_result", seen, 0);

      // abort wins over start in IDLE.
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_start_busy", busy, 0);
      tick();
      check("abort_start_busy2", {busy, resValid}, 0);

      // Reset during CLOSE clears everything.
      prep(20, 21, 1000);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (45) tick();
      check("pre_rst_busy", busy, 1);
      sysRst = 1'b1;
      #1;
      check("mid_rst_busy_valid", {busy, resValid}, 0);
      check("mid_rst_counts", {refCount, sigCount}, 0);
      check("mid_rst_flags", {timeout, overflow}, 0);
      tick();
      sysRst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
